// File: rtl/fp_mult_exc_stage.sv
// ============================================================================
// fp_mult_exc_stage : registered IEEE-754 single exception/output stage for fp_mult
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_mult_exc_stage #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [2:0]       rnd,
  input  logic             sign_in,
  input  logic [9:0]       exp_in,
  input  logic [22:0]      mant_in,
  input  logic             inexact_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      z,
  output logic [7:0]       status,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_nan,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic [CNT_W-1:0] cnt_unf
);

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam logic [2:0] RND_NEAR    = 3'd0;
  localparam logic [2:0] RND_PINF    = 3'd2;
  localparam logic [2:0] RND_NINF    = 3'd3;
  localparam logic [2:0] RND_NEAR_UP = 3'd4;
  localparam logic [2:0] RND_AWAY    = 3'd5;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // Denormals are flushed to zero, so any exp==0 operand classifies as zero.
  function automatic logic [1:0] classify(input logic [30:0] op);
    logic [1:0] cls;
    cls = CLS_NORM;
    if (op[30:23] == 8'h00)
      cls = CLS_ZERO;
    else if (op[30:23] == 8'hFF)
      cls = (op[22:0] == 23'h0) ? CLS_INF : CLS_NAN;
    return cls;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             r_s1_valid;
  logic [1:0]       r_cls_a;
  logic [1:0]       r_cls_b;
  logic             r_sign;
  logic [9:0]       r_exp;
  logic [22:0]      r_mant;
  logic             r_inexact;
  logic [2:0]       r_rnd;

  logic             r_s2_valid;
  logic [31:0]      r_z;
  logic [7:0]       r_status;
  logic [CNT_W-1:0] r_cnt_nan;
  logic [CNT_W-1:0] r_cnt_ovf;
  logic [CNT_W-1:0] r_cnt_unf;

  logic        w_adv1;
  logic        w_adv2;
  logic        w_load2;
  logic [2:0]  w_rnd_dec;
  logic        w_invalid;
  logic        w_any_inf;
  logic        w_any_zero;
  logic        w_ovf_to_inf;
  logic        w_unf_to_min;
  logic [31:0] w_z;
  logic [7:0]  w_status;
  logic        w_is_nan;
  logic        w_is_ovf;
  logic        w_is_unf;
  logic        w_unused;

  assign w_unused  = a[31] ^ b[31];

  assign w_adv2    = !r_s2_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign w_load2   = w_adv2 && r_s1_valid;
  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign z         = r_z;
  assign status    = r_status;
  assign cnt_nan   = r_cnt_nan;
  assign cnt_ovf   = r_cnt_ovf;
  assign cnt_unf   = r_cnt_unf;

  assign w_rnd_dec = (rnd > RND_AWAY) ? RND_NEAR : rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_cls_a    <= CLS_NORM;
      r_cls_b    <= CLS_NORM;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_inexact  <= 1'b0;
      r_rnd      <= RND_NEAR;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_cls_a   <= classify(a[30:0]);
        r_cls_b   <= classify(b[30:0]);
        r_sign    <= sign_in;
        r_exp     <= exp_in;
        r_mant    <= mant_in;
        r_inexact <= inexact_in;
        r_rnd     <= w_rnd_dec;
      end
    end
  end

  assign w_invalid  = (r_cls_a == CLS_NAN) || (r_cls_b == CLS_NAN) ||
                      ((r_cls_a == CLS_INF) && (r_cls_b == CLS_ZERO)) ||
                      ((r_cls_a == CLS_ZERO) && (r_cls_b == CLS_INF));
  assign w_any_inf  = (r_cls_a == CLS_INF) || (r_cls_b == CLS_INF);
  assign w_any_zero = (r_cls_a == CLS_ZERO) || (r_cls_b == CLS_ZERO);

  // Directed modes that round away from zero in the result's direction.
  assign w_ovf_to_inf = (r_rnd == RND_NEAR) || (r_rnd == RND_NEAR_UP) || (r_rnd == RND_AWAY) ||
                        ((r_rnd == RND_PINF) && !r_sign) || ((r_rnd == RND_NINF) && r_sign);
  assign w_unf_to_min = (r_rnd == RND_AWAY) ||
                        ((r_rnd == RND_PINF) && !r_sign) || ((r_rnd == RND_NINF) && r_sign);

  always_comb begin
    w_z      = '0;
    w_status = '0;
    w_is_nan = 1'b0;
    w_is_ovf = 1'b0;
    w_is_unf = 1'b0;
    if (w_invalid) begin
      w_z              = QNAN;
      w_status[ST_NAN] = 1'b1;
      w_is_nan         = 1'b1;
    end else if (w_any_inf) begin
      w_z              = {r_sign, 8'hFF, 23'h0};
      w_status[ST_INF] = 1'b1;
    end else if (w_any_zero) begin
      w_z               = {r_sign, 31'h0};
      w_status[ST_ZERO] = 1'b1;
    end else if ($signed(r_exp) >= 10'sd255) begin
      w_is_ovf             = 1'b1;
      w_status[ST_HUGE]    = 1'b1;
      w_status[ST_INEXACT] = 1'b1;
      if (w_ovf_to_inf) begin
        w_z              = {r_sign, 8'hFF, 23'h0};
        w_status[ST_INF] = 1'b1;
      end else begin
        w_z = {r_sign, 8'hFE, 23'h7FFFFF};
      end
    end else if ($signed(r_exp) <= 10'sd0) begin
      w_is_unf             = 1'b1;
      w_status[ST_TINY]    = 1'b1;
      w_status[ST_INEXACT] = 1'b1;
      if (w_unf_to_min) begin
        w_z = {r_sign, 8'h01, 23'h0};
      end else begin
        w_z               = {r_sign, 31'h0};
        w_status[ST_ZERO] = 1'b1;
      end
    end else begin
      w_z                  = {r_sign, r_exp[7:0], r_mant};
      w_status[ST_INEXACT] = r_inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_z        <= '0;
      r_status   <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_z      <= w_z;
        r_status <= w_status;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_nan <= '0;
      r_cnt_ovf <= '0;
      r_cnt_unf <= '0;
    end else if (cnt_clr) begin
      r_cnt_nan <= '0;
      r_cnt_ovf <= '0;
      r_cnt_unf <= '0;
    end else if (w_load2) begin
      if (w_is_nan) r_cnt_nan <= sat_inc(r_cnt_nan);
      if (w_is_ovf) r_cnt_ovf <= sat_inc(r_cnt_ovf);
      if (w_is_unf) r_cnt_unf <= sat_inc(r_cnt_unf);
    end
  end

endmodule

`default_nettype wire
